ppg_seq: RTL

- Sequencer for the lattice-gas propagation datapath (3-row BRAM line buffer plus propagation logic).
- Per frame it does three things:
  - loads lattice rows from VRAM into the line buffer using PPGRD phases;
  - runs PPGCL calc phases that stream propagated words back to VRAM;
  - advances the row pointer.
- Source and destination planes ping-pong every frame. Top/bottom rows are walls and are not rewritten.

---
 rtl/ppg_seq_if.sv | 25 ++
 rtl/ppg_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ppg_seq_if.sv
// VRAM / datapath bus of the lattice-gas propagation sequencer.
// master = sequencer, slave = datapath + VRAM side.
interface ppg_seq_if;
    logic        PPGRD;
    logic        PPGCL;
    logic [9:0]  C_VRAMADR_X;
    logic [13:0] C_VRAMADR_Y;
    logic        vram_req;
    logic        vram_we;
    logic        vram_ack;
    logic        rdata_valid;
    logic [9:0]  wr_col;

    modport master (
        output PPGRD, PPGCL, C_VRAMADR_X, C_VRAMADR_Y,
        output vram_req, vram_we, wr_col,
        input  vram_ack, rdata_valid
    );

    modport slave (
        input  PPGRD, PPGCL, C_VRAMADR_X, C_VRAMADR_Y,
        input  vram_req, vram_we, wr_col,
        output vram_ack, rdata_valid
    );
endinterface

// File: rtl/ppg_seq.sv
// Frame sequencer for the lattice-gas propagation datapath:
// row loads (PPGRD), row calcs (PPGCL) and ping-pong planes.
module ppg_seq #(
    parameter logic [13:0] DST_OFS  = 14'd512,
    parameter int          CALC_LAT = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [9:0] dsizx,
    input  logic [9:0] dsizy,
    output logic       busy,
    output logic       done,
    output logic       plane,
    ppg_seq_if.master  bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE0 = 3'd1;
    localparam logic [2:0] S_PRE1 = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_CALC = 3'd4;
    localparam logic [2:0] S_GAP  = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;

    logic [2:0]          state;
    logic [2:0]          nxt;
    logic [9:0]          wx;
    logic [9:0]          ny;
    logic [9:0]          x;
    logic [9:0]          beat;
    logic [9:0]          wcnt;
    logic [13:0]         y;
    logic [13:0]         ya;
    logic                rd;
    logic                cl;
    logic                rd_req;
    logic                iss;
    logic [CALC_LAT-1:0] wv;
    logic [9:0]          wc [CALC_LAT];

    logic        stall;
    logic        wr_ack;
    logic        row_last;
    logic [13:0] src_ofs;
    logic [13:0] dst_ofs;
    logic [13:0] rd_row;

    // Plane offset only touches bits [13:9]; [8:0] stay base-relative
    // so the datapath bank select sees the true row in both phases.
    assign src_ofs  = plane ? DST_OFS : 14'd0;
    assign dst_ofs  = plane ? 14'd0 : DST_OFS;
    assign rd_row   = (nxt == S_PRE1) ? 14'd1 : y + 14'd1;
    assign stall    = wv[CALC_LAT-1] & ~bus.vram_ack;
    assign wr_ack   = wv[CALC_LAT-1] & bus.vram_ack;
    assign row_last = (y == {4'd0, ny} - 14'd1);

    assign bus.PPGRD       = rd;
    assign bus.PPGCL       = cl;
    assign bus.C_VRAMADR_X = x;
    assign bus.C_VRAMADR_Y = ya;
    assign bus.vram_req    = rd_req | wv[CALC_LAT-1];
    assign bus.vram_we     = wv[CALC_LAT-1];
    assign bus.wr_col      = wc[CALC_LAT-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            nxt    <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            plane  <= 1'b0;
            wx     <= '0;
            ny     <= '0;
            x      <= '0;
            beat   <= '0;
            wcnt   <= '0;
            y      <= '0;
            ya     <= '0;
            rd     <= 1'b0;
            cl     <= 1'b0;
            rd_req <= 1'b0;
            iss    <= 1'b0;
            wv     <= '0;
            for (int i = 0; i < CALC_LAT; i++) wc[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        wx   <= dsizx;
                        ny   <= dsizy;
                        y    <= 14'd1;
                        if (dsizy < 10'd2) begin
                            state <= S_FIN;
                        end else begin
                            state  <= S_PRE0;
                            rd     <= 1'b1;
                            rd_req <= 1'b1;
                            beat   <= '0;
                            ya     <= src_ofs;
                        end
                    end
                end
                S_PRE0, S_PRE1, S_RD: begin
                    if (bus.vram_ack) rd_req <= 1'b0;
                    if (bus.rdata_valid) begin
                        if (beat == wx) begin
                            rd     <= 1'b0;
                            rd_req <= 1'b0;
                            state  <= S_GAP;
                            // row y+1 must be resident before row y is computed
                            nxt    <= (state == S_PRE0) ? S_PRE1 :
                                      (state == S_PRE1) ? S_RD : S_CALC;
                        end else begin
                            beat <= beat + 10'd1;
                        end
                    end
                end
                S_GAP: begin
                    state <= nxt;
                    if (nxt == S_CALC) begin
                        cl   <= 1'b1;
                        x    <= '0;
                        iss  <= 1'b1;
                        wcnt <= '0;
                        ya   <= y + dst_ofs;
                    end else begin
                        rd     <= 1'b1;
                        rd_req <= 1'b1;
                        beat   <= '0;
                        ya     <= rd_row + src_ofs;
                    end
                end
                S_CALC: begin
                    if (!stall) begin
                        for (int i = CALC_LAT - 1; i > 0; i--) begin
                            wv[i] <= wv[i-1];
                            wc[i] <= wc[i-1];
                        end
                        wv[0] <= iss;
                        wc[0] <= x;
                        if (iss) begin
                            if (x == wx) iss <= 1'b0;
                            else         x   <= x + 10'd1;
                        end
                    end
                    if (wr_ack) begin
                        if (wcnt == wx) begin
                            cl   <= 1'b0;
                            x    <= '0;
                            wcnt <= '0;
                            if (row_last) begin
                                state <= S_FIN;
                            end else begin
                                y     <= y + 14'd1;
                                state <= S_GAP;
                                nxt   <= S_RD;
                            end
                        end else begin
                            wcnt <= wcnt + 10'd1;
                        end
                    end
                end
                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    plane <= ~plane;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
